// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter feeding a JK state-bit bank.
// One command per cycle; applied one edge after accept, with an ack.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3,
  parameter int GIDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_jk,
  input  logic [IDXW*NREQ-1:0]   req_idx,
  output logic [NBITS-1:0]       q,
  output logic                   ack_valid,
  output logic [GIDW-1:0]        ack_id,
  output logic                   ack_prev,
  output logic                   ack_err
);

  logic [GIDW-1:0]  rr_ptr;
  logic [GIDW-1:0]  gnt_id;
  logic [GIDW-1:0]  nxt_ptr;
  logic [1:0]       gnt_jk;
  logic [IDXW-1:0]  gnt_idx;
  logic             found;
  logic             xfer;
  int               scan;

  logic             cmd_valid;
  logic [GIDW-1:0]  cmd_id;
  logic [1:0]       cmd_jk;
  logic [IDXW-1:0]  cmd_idx;

  logic             in_range;
  logic             old_bit;
  logic [NBITS-1:0] q_next;

  // Scan requesters from rr_ptr upward; first valid one wins.
  always_comb begin
    req_ready = '0;
    found     = 1'b0;
    gnt_id    = '0;
    gnt_jk    = '0;
    gnt_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!found && req_valid[scan]) begin
        found           = 1'b1;
        req_ready[scan] = 1'b1;
        gnt_id          = GIDW'(scan);
        gnt_jk          = req_jk[2*scan +: 2];
        gnt_idx         = req_idx[IDXW*scan +: IDXW];
      end
    end
    if (rst) begin
      req_ready = '0;
      found     = 1'b0;
    end
  end

  assign xfer    = found;
  assign nxt_ptr = (int'(gnt_id) == NREQ-1) ? '0
                                            : gnt_id + 1'b1;

  // Decode the staged command against the current bank value.
  always_comb begin
    in_range = 1'b0;
    old_bit  = 1'b0;
    q_next   = q;
    for (int b = 0; b < NBITS; b++) begin
      if (int'(cmd_idx) == b) begin
        in_range = 1'b1;
        old_bit  = q[b];
        case (cmd_jk)
          2'b01:   q_next[b] = 1'b0;
          2'b10:   q_next[b] = 1'b1;
          2'b11:   q_next[b] = ~q[b];
          default: q_next[b] = q[b];
        endcase
      end
    end
  end

  // Round-robin pointer advances past each granted requester.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (xfer) rr_ptr <= nxt_ptr;
  end

  // Stage 1: capture the accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      cmd_jk    <= '0;
      cmd_idx   <= '0;
    end else begin
      cmd_valid <= xfer;
      if (xfer) begin
        cmd_id  <= gnt_id;
        cmd_jk  <= gnt_jk;
        cmd_idx <= gnt_idx;
      end
    end
  end

  // Stage 2: apply to the bank and register the acknowledgement.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      ack_valid <= 1'b0;
      ack_id    <= '0;
      ack_prev  <= 1'b0;
      ack_err   <= 1'b0;
    end else begin
      ack_valid <= cmd_valid;
      if (cmd_valid) begin
        q        <= q_next;
        ack_id   <= cmd_id;
        ack_prev <= old_bit;
        ack_err  <= ~in_range;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbiter and JK bank.
module tb_jk_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDXW  = 4;
  localparam int GIDW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_jk;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NBITS-1:0]     q;
  logic                 ack_valid;
  logic [GIDW-1:0]      ack_id;
  logic                 ack_prev;
  logic                 ack_err;

  logic [1:0]      rjk  [NREQ];
  logic [IDXW-1:0] ridx [NREQ];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [GIDW-1:0] id;
    logic [1:0]      jk;
    logic [IDXW-1:0] idx;
  } cmd_t;

  cmd_t            pq[$];
  logic [NBITS-1:0] m_q;
  int              m_ptr;
  int              last_g;
  logic            e_av;
  logic [GIDW-1:0] e_id;
  logic            e_prev;
  logic            e_err;

  jk_bank_arbiter #(
    .NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW), .GIDW(GIDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_jk(req_jk), .req_idx(req_idx),
    .q(q), .ack_valid(ack_valid), .ack_id(ack_id),
    .ack_prev(ack_prev), .ack_err(ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_jk  = '0;
    req_idx = '0;
    for (int r = 0; r < NREQ; r++) begin
      req_jk[2*r +: 2]       = rjk[r];
      req_idx[IDXW*r +: IDXW] = ridx[r];
    end
  end

  function automatic int model_grant();
    int r;
    if (rst) return -1;
    for (int k = 0; k < NREQ; k++) begin
      r = (m_ptr + k) % NREQ;
      if (req_valid[r]) return r;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] v;
    int g;
    v = '0;
    g = model_grant();
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    int g;
    cmd_t c;
    g = model_grant();
    @(posedge clk);
    if (rst) begin
      pq.delete();
      m_q = '0; m_ptr = 0; last_g = -1;
      e_av = 0; e_id = '0; e_prev = 0; e_err = 0;
    end else begin
      if (pq.size() > 0) begin
        c = pq.pop_front();
        e_av = 1; e_id = c.id;
        if (int'(c.idx) >= NBITS) begin
          e_prev = 0; e_err = 1;
        end else begin
          e_prev = m_q[c.idx]; e_err = 0;
          if (c.jk == 2'b01) m_q[c.idx] = 1'b0;
          if (c.jk == 2'b10) m_q[c.idx] = 1'b1;
          if (c.jk == 2'b11) m_q[c.idx] = ~m_q[c.idx];
        end
      end else begin
        e_av = 0;
      end
      last_g = g;
      if (g >= 0) begin
        c.id = GIDW'(g); c.jk = rjk[g]; c.idx = ridx[g];
        pq.push_back(c);
        m_ptr = (g + 1) % NREQ;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = '1;
    for (int r = 0; r < NREQ; r++) begin
      rjk[r] = 2'b10; ridx[r] = IDXW'(r);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (req_ready !== '0)
        $display("FAIL reset_ready: got %b want 0000", req_ready);
      else passed++;
      tick();
    end
    rst = 0;
    total++;
    if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q);
    else passed++;
    total++;
    if (ack_valid !== 1'b0)
      $display("FAIL reset_ack: got %b want 0", ack_valid);
    else passed++;
    #1;
    total++;
    if (req_ready !== 4'b0001)
      $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    else passed++;
    req_valid = '0;
    #1;
  endtask

  task automatic test_basic();
    logic [1:0] seq [3];
    logic [2:0] qexp, pexp;
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b11;
    qexp = 3'b101; pexp = 3'b010;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        req_valid = 4'b0010; rjk[1] = seq[i]; ridx[1] = 3;
        #1;
        total++;
        if (req_ready !== 4'b0010)
          $display("FAIL basic_ready: got %b want 0010", req_ready);
        else passed++;
      end else begin
        req_valid = '0;
      end
      tick();
      if (i > 0) begin
        total++;
        if (q[3] !== qexp[3-i] || ack_valid !== 1'b1)
          $display("FAIL basic_q3 step %0d: got q3=%b av=%b want q3=%b av=1",
                   i, q[3], ack_valid, qexp[3-i]);
        else passed++;
        total++;
        if (ack_prev !== pexp[3-i] || ack_id !== 2'd1)
          $display("FAIL basic_ack step %0d: got prev=%b id=%0d want prev=%b id=1",
                   i, ack_prev, ack_id, pexp[3-i]);
        else passed++;
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = '1;
    for (int r = 0; r < NREQ; r++) begin
      rjk[r] = 2'b10; ridx[r] = IDXW'(r);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (req_ready !== 4'(1 << (i % NREQ)))
        $display("FAIL rr_order step %0d: got %b want %b",
                 i, req_ready, 4'(1 << (i % NREQ)));
      else passed++;
      tick();
    end
    req_valid = '0;
    tick();
    total++;
    if (q !== 8'h0F) $display("FAIL rr_q: got %h want 0f", q);
    else passed++;
    tick();
  endtask

  task automatic test_pointer();
    do_reset();
    req_valid = 4'b0100; rjk[2] = 2'b00; ridx[2] = 6;
    tick();
    req_valid = 4'b0101; rjk[0] = 2'b11; ridx[0] = 1;
    #1;
    total++;
    if (req_ready !== 4'b0001)
      $display("FAIL ptr_first: got %b want 0001", req_ready);
    else passed++;
    tick();
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100)
      $display("FAIL ptr_second: got %b want 0100", req_ready);
    else passed++;
    tick();
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_out_of_range();
    logic [NBITS-1:0] qb;
    qb = m_q;
    req_valid = 4'b0001; rjk[0] = 2'b10; ridx[0] = 9;
    #1;
    total++;
    if (req_ready !== 4'b0001)
      $display("FAIL oor_accept: got %b want 0001", req_ready);
    else passed++;
    tick();
    req_valid = '0;
    tick();
    total++;
    if (ack_valid !== 1'b1 || ack_err !== 1'b1 || ack_prev !== 1'b0)
      $display("FAIL oor_ack: got av=%b err=%b prev=%b want 1 1 0",
               ack_valid, ack_err, ack_prev);
    else passed++;
    total++;
    if (q !== qb) $display("FAIL oor_q: got %h want %h", q, qb);
    else passed++;
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'b0001; rjk[0] = 2'b10; ridx[0] = 5;
    tick();
    req_valid = '0; rst = 1;
    tick();
    total++;
    if (ack_valid !== 1'b0 || q[5] !== 1'b0)
      $display("FAIL midrst_during: got av=%b q5=%b want 0 0",
               ack_valid, q[5]);
    else passed++;
    rst = 0;
    tick();
    total++;
    if (ack_valid !== 1'b0 || q !== 8'h00)
      $display("FAIL midrst_after: got av=%b q=%h want 0 00",
               ack_valid, q);
    else passed++;
  endtask

  task automatic test_random();
    int wait_cnt [NREQ];
    logic [NREQ-1:0] vb;
    do_reset();
    for (int r = 0; r < NREQ; r++) wait_cnt[r] = 0;
    req_valid = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(63) == 0);
      #1;
      total++;
      if (req_ready !== model_ready())
        $display("FAIL rnd_ready cyc %0d: got %b want %b",
                 cyc, req_ready, model_ready());
      else passed++;
      vb = req_valid;
      tick();
      total++;
      if (q !== m_q || ack_valid !== e_av)
        $display("FAIL rnd_state cyc %0d: got q=%h av=%b want q=%h av=%b",
                 cyc, q, ack_valid, m_q, e_av);
      else passed++;
      if (e_av) begin
        total++;
        if (ack_id !== e_id || ack_prev !== e_prev || ack_err !== e_err)
          $display("FAIL rnd_ack cyc %0d: got id=%0d p=%b e=%b want id=%0d p=%b e=%b",
                   cyc, ack_id, ack_prev, ack_err, e_id, e_prev, e_err);
        else passed++;
      end
      if (rst) begin
        for (int r = 0; r < NREQ; r++) wait_cnt[r] = 0;
      end else if (last_g >= 0) begin
        for (int r = 0; r < NREQ; r++)
          if (vb[r] && r != last_g) wait_cnt[r]++;
        total++;
        if (wait_cnt[last_g] > NREQ-1)
          $display("FAIL rnd_starve req %0d: waited %0d want <= %0d",
                   last_g, wait_cnt[last_g], NREQ-1);
        else passed++;
        wait_cnt[last_g] = 0;
        req_valid[last_g] = 1'b0;
      end
      rst = 0;
      for (int r = 0; r < NREQ; r++) begin
        if (!req_valid[r] && $urandom_range(2) != 0) begin
          req_valid[r] = 1'b1;
          rjk[r]  = 2'($urandom);
          ridx[r] = IDXW'($urandom_range(NBITS+1));
        end
      end
    end
    req_valid = '0;
    tick(); tick();
  endtask

  initial begin
    rst = 1; req_valid = '0;
    for (int r = 0; r < NREQ; r++) begin
      rjk[r] = '0; ridx[r] = '0;
    end
    m_q = '0; m_ptr = 0; last_g = -1;
    e_av = 0; e_id = '0; e_prev = 0; e_err = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_out_of_range();
    test_pointer();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin command arbiter and sequencer for a bank of JK-style state bits. NREQ requesters each issue single-bit JK commands (hold/reset/set/toggle) with an index over a valid/ready handshake. The block grants one command per cycle and applies it to its internal NBITS-wide JK bank one cycle later. It returns a per-command acknowledgement carrying the bit's previous value. It sits between software/control agents and the flag/state bits they share, so that concurrent toggles and sets on one bank are serialised deterministically.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of JK state bits in the bank
- IDXW, 3, bit-index width; 2**IDXW >= NBITS
- GIDW, 2, requester-id width; 2**GIDW >= NREQ

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_jk  in  2*NREQ  requester r uses bits [2r+1:2r] = {J,K}
- req_idx  in  IDXW*NREQ  requester r uses bits [IDXW*r +: IDXW]
- q  out  NBITS  JK bank state
- ack_valid  out  1  one-cycle pulse when a command has been applied
- ack_id  out  GIDW  requester that issued the applied command
- ack_prev  out  1  bank bit value before the command was applied
- ack_err  out  1  command index was >= NBITS

## Operation
- Handshake:
  - A transfer occurs on requester r when req_valid[r] & req_ready[r] at a rising edge.
  - Requesters hold valid high and keep jk/idx stable until accepted.
  - req_ready may depend combinationally on req_valid.
- Arbitration:
  - Round-robin pointer rr_ptr (GIDW bits).
  - The grant goes to the first r with req_valid[r] set, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is the one-hot grant; all zeros when no valid is set or rst is high.
  - On a transfer, rr_ptr <= (granted r + 1) mod NREQ. Without a transfer, rr_ptr holds.
- Stage 1: an accepted command is registered into cmd_valid/cmd_id/cmd_jk/cmd_idx. cmd_valid clears when there is no transfer.
- Stage 2: when cmd_valid is set, the command is applied to q[cmd_idx], reading the current q value at apply time:
  - 00: hold
  - 01: bit <= 0
  - 10: bit <= 1
  - 11: bit <= ~bit
- Acknowledge: in the same edge as apply, the block registers ack_valid=1, ack_id=cmd_id, ack_prev=old bit and ack_err=0.
- Out-of-range index (cmd_idx >= NBITS):
  - The command is accepted normally and q is unchanged.
  - The ack carries ack_err=1 and ack_prev=0.
- Hold (00) commands still produce an ack with ack_prev equal to the current bit.
- Back-to-back commands to the same bit need no stall: each applies in order and sees the result of the previous one.
- Throughput: one command per cycle sustained. The block never stalls for bank reasons.

## Timing
- Reset: rst high at an edge sets
  - q = 0
  - rr_ptr = 0
  - cmd_valid = 0
  - ack_valid = 0, ack_id = 0, ack_prev = 0, ack_err = 0
- Reset mid-operation: a command accepted in the cycle before rst is discarded. No ack is issued and q is still cleared.
- While rst is high, req_ready = 0.
- Latency, for a transfer at edge N:
  - The cmd register is loaded at N.
  - q update and ack_valid=1 are both visible after edge N+1.
  - ack_valid falls after N+2 unless another command follows.
- ack_valid is never high for more than one cycle per command. Acks appear in grant order.
- Simultaneous valids: exactly one is granted per edge. Losers keep valid high and are served within NREQ-1 further grants (starvation-free).

## Test plan
- Reset value:
  - Stimulus: drive rst=1 for 2 cycles with all req_valid=1.
  - Required: req_ready=0 throughout. After release, q=0x00, ack_valid=0, and the first grant goes to requester 0.
- Basic set/toggle:
  - Stimulus: requester 1 sends set idx 3, then toggle idx 3, then toggle idx 3 on consecutive cycles.
  - Required: q[3] goes 1, 0, 1 at N+1, N+2, N+3. ack_prev is 0, 1, 0, and ack_id=1 each time.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid continuously, each issuing set on its own index 0..3.
  - Required: grant order is 0, 1, 2, 3, 0. q=0x0F after the fifth edge plus one.
- Pointer continuity:
  - Stimulus: only requesters 2 and 0 are valid, with rr_ptr=3.
  - Required: 0 is granted first, then 2.
- Out-of-range index:
  - Stimulus: requester 0 sends set idx 9 with NBITS=8, IDXW=4.
  - Required: transfer accepted, q unchanged, ack_err=1, ack_prev=0.
- Reset mid-flight:
  - Stimulus: set idx 5 is accepted at edge N and rst=1 at edge N+1.
  - Required: no ack_valid pulse and q[5]=0.
